// File: rtl/s1c88_fetch_unit.sv
// S1C88 instruction fetch front end: PC walk, opcode/extension/immediate assembly, valid/ready handoff.
// Optional code banking of the upper 32 KiB is compiled in with S1C88_FETCH_BANK_EN.
module s1c88_fetch_unit #(
   parameter int          ADDR_WIDTH    = 24,
   parameter int          MAX_IMM_BYTES = 2,
   parameter logic [15:0] RESET_PC      = 16'h0000,
   localparam int         IW            = $clog2(MAX_IMM_BYTES + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pc_load,
   input  logic [15:0]                pc_load_value,
   input  logic [7:0]                 cb,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   output logic                       mem_read,
   input  logic                       mem_ready,
   input  logic [7:0]                 mem_data_in,
   output logic [7:0]                 dec_opcode,
   output logic [7:0]                 dec_opext,
   input  logic                       dec_need_opext,
   input  logic [IW-1:0]              dec_imm_bytes,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [7:0]                 instr_opcode,
   output logic [7:0]                 instr_opext,
   output logic                       instr_has_opext,
   output logic [8*MAX_IMM_BYTES-1:0] instr_imm,
   output logic [IW-1:0]              instr_imm_bytes,
   output logic [15:0]                instr_pc,
   output logic [15:0]                pc
);

   // state  | meaning
   // IDLE   | first cycle after reset
   // OPCODE | fetching opcode byte
   // OPEXT  | fetching extension byte
   // IMM    | fetching immediate bytes
   // HOLD   | instruction offered to execute stage
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_OPCODE = 3'd1;
   localparam logic [2:0] S_OPEXT  = 3'd2;
   localparam logic [2:0] S_IMM    = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   localparam logic [IW-1:0] IMM_MAX = IW'(MAX_IMM_BYTES);

   logic [2:0]                 state;
   logic [15:0]                pc_q;
   logic [7:0]                 opcode_q;
   logic [7:0]                 opext_q;
   logic                       has_opext_q;
   logic [8*MAX_IMM_BYTES-1:0] imm_q;
   logic [IW-1:0]              imm_cnt;
   logic [IW-1:0]              imm_total;
   logic [15:0]                instr_pc_q;
   logic [IW-1:0]              imm_clamped;
   logic [IW-1:0]              imm_cnt_next;

   assign imm_clamped  = (dec_imm_bytes > IMM_MAX) ? IMM_MAX : dec_imm_bytes;
   assign imm_cnt_next = imm_cnt + IW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pc_q        <= RESET_PC;
         opcode_q    <= 8'h00;
         opext_q     <= 8'h00;
         has_opext_q <= 1'b0;
         imm_q       <= '0;
         imm_cnt     <= '0;
         imm_total   <= '0;
         instr_pc_q  <= 16'h0000;
      end else if (pc_load) begin
         // any byte arriving this cycle is dropped; an accepted HOLD simply ends here too
         state <= S_OPCODE;
         pc_q  <= pc_load_value;
      end else begin
         case (state)
            S_IDLE: state <= S_OPCODE;
            S_OPCODE: if (mem_ready) begin
               pc_q        <= pc_q + 16'd1;
               opcode_q    <= mem_data_in;
               instr_pc_q  <= pc_q;
               opext_q     <= 8'h00;
               has_opext_q <= 1'b0;
               imm_q       <= '0;
               imm_cnt     <= '0;
               if (dec_need_opext) begin
                  imm_total <= '0;
                  state     <= S_OPEXT;
               end else begin
                  imm_total <= imm_clamped;
                  state     <= (imm_clamped == '0) ? S_HOLD : S_IMM;
               end
            end
            S_OPEXT: if (mem_ready) begin
               pc_q        <= pc_q + 16'd1;
               opext_q     <= mem_data_in;
               has_opext_q <= 1'b1;
               imm_total   <= imm_clamped;
               state       <= (imm_clamped == '0) ? S_HOLD : S_IMM;
            end
            S_IMM: if (mem_ready) begin
               pc_q <= pc_q + 16'd1;
               for (int k = 0; k < MAX_IMM_BYTES; k++) begin
                  if (imm_cnt == IW'(k)) imm_q[8*k +: 8] <= mem_data_in;
               end
               imm_cnt <= imm_cnt_next;
               if (imm_cnt_next == imm_total) state <= S_HOLD;
            end
            S_HOLD: if (instr_ready) state <= S_OPCODE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mem_read    = (state == S_OPCODE) || (state == S_OPEXT) || (state == S_IMM);
   assign instr_valid = (state == S_HOLD);

   assign dec_opcode = (state == S_OPCODE) ? mem_data_in : opcode_q;
   assign dec_opext  = (state == S_OPEXT)  ? mem_data_in : opext_q;

`ifdef S1C88_FETCH_BANK_EN
   assign mem_addr = pc_q[15] ? ADDR_WIDTH'({cb, pc_q[14:0]})
                              : ADDR_WIDTH'({8'h00, pc_q[14:0]});
`else
   logic unused_cb;
   assign unused_cb = ^cb;
   assign mem_addr  = ADDR_WIDTH'(pc_q);
`endif

   assign instr_opcode    = opcode_q;
   assign instr_opext     = opext_q;
   assign instr_has_opext = has_opext_q;
   assign instr_imm       = imm_q;
   assign instr_imm_bytes = imm_total;
   assign instr_pc        = instr_pc_q;
   assign pc              = pc_q;

endmodule

// File: tb/tb_s1c88_fetch_unit.sv
// Directed bench for s1c88_fetch_unit: vector table of single instructions plus
// hand sequences for reset, wait states, HOLD stall, PC redirect and bank crossing.
module tb_s1c88_fetch_unit;

   localparam int ADDR_WIDTH = 24;
   localparam int MAXI       = 2;
   localparam int IW         = $clog2(MAXI + 1);
   localparam logic [7:0] CB_VAL = 8'h05;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  pc_load;
   logic [15:0]           pc_load_value;
   logic [7:0]            cb;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read;
   logic                  mem_ready;
   logic [7:0]            mem_data_in;
   logic [7:0]            dec_opcode;
   logic [7:0]            dec_opext;
   logic                  dec_need_opext;
   logic [IW-1:0]         dec_imm_bytes;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [7:0]            instr_opcode;
   logic [7:0]            instr_opext;
   logic                  instr_has_opext;
   logic [8*MAXI-1:0]     instr_imm;
   logic [IW-1:0]         instr_imm_bytes;
   logic [15:0]           instr_pc;
   logic [15:0]           pc;

   s1c88_fetch_unit #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_IMM_BYTES(MAXI), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .pc_load(pc_load), .pc_load_value(pc_load_value), .cb(cb),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_ready(mem_ready), .mem_data_in(mem_data_in),
      .dec_opcode(dec_opcode), .dec_opext(dec_opext), .dec_need_opext(dec_need_opext),
      .dec_imm_bytes(dec_imm_bytes), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_opcode(instr_opcode), .instr_opext(instr_opext), .instr_has_opext(instr_has_opext),
      .instr_imm(instr_imm), .instr_imm_bytes(instr_imm_bytes), .instr_pc(instr_pc), .pc(pc)
   );

   always #5 clk = ~clk;

   // byte memory seen through the CPU's 16-bit PC view
   logic [7:0] mem [0:65535];

   function automatic logic [15:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
`ifdef S1C88_FETCH_BANK_EN
      return {|a[22:15], a[14:0]};
`else
      return a[15:0];
`endif
   endfunction

   function automatic logic [31:0] exp_addr(input logic [15:0] p);
`ifdef S1C88_FETCH_BANK_EN
      return p[15] ? {9'h0, CB_VAL, p[14:0]} : {17'h0, p[14:0]};
`else
      return {16'h0, p};
`endif
   endfunction

   assign mem_data_in = mem[mem_idx(mem_addr)];

   // toy decoder: CE takes an extension; 3F asks for 3 immediates to exercise clamping
   assign dec_need_opext = (dec_opcode == 8'hCE);
   always_comb begin
      dec_imm_bytes = '0;
      case (dec_opcode)
         8'h10: dec_imm_bytes = 2'd1;
         8'h30: dec_imm_bytes = 2'd2;
         8'h3F: dec_imm_bytes = 2'd3;
         8'hCE: dec_imm_bytes = (dec_opext == 8'h44) ? 2'd2 : 2'd0;
         default: dec_imm_bytes = '0;
      endcase
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to_valid(output int cyc);
      cyc = 0;
      while (!instr_valid && cyc < 50) begin
         tick();
         cyc++;
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [31:0] bytes;
      logic [7:0]  op;
      logic [7:0]  ext;
      logic        has;
      logic [15:0] imm;
      logic [1:0]  nb;
      logic [15:0] npc;
      int          cyc;
   } vec_t;

   vec_t vt [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      logic [0:6] rs;
      logic [15:0] xa [7];

      vt[0] = '{16'h0100, 32'h0000_0020, 8'h20, 8'h00, 1'b0, 16'h0000, 2'd0, 16'h0101, 1};
      vt[1] = '{16'h0200, 32'h0000_AB10, 8'h10, 8'h00, 1'b0, 16'h00AB, 2'd1, 16'h0202, 2};
      vt[2] = '{16'h0300, 32'h0012_3430, 8'h30, 8'h00, 1'b0, 16'h1234, 2'd2, 16'h0303, 3};
      vt[3] = '{16'h0400, 32'h0000_45CE, 8'hCE, 8'h45, 1'b1, 16'h0000, 2'd0, 16'h0402, 2};
      vt[4] = '{16'h0500, 32'h5678_44CE, 8'hCE, 8'h44, 1'b1, 16'h5678, 2'd2, 16'h0504, 4};
      vt[5] = '{16'h0600, 32'h3322_113F, 8'h3F, 8'h00, 1'b0, 16'h2211, 2'd2, 16'h0603, 3};
      vt[6] = '{16'hFFFF, 32'h0000_5A10, 8'h10, 8'h00, 1'b0, 16'h005A, 2'd1, 16'h0001, 2};

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0000] = 8'h20;
      reset = 1'b1; pc_load = 1'b0; pc_load_value = 16'h0000; cb = CB_VAL;
      mem_ready = 1'b1; instr_ready = 1'b0;

      // reset state and first instruction
      tick(); tick();
      chk("rst_valid", instr_valid, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_opcode", instr_opcode, 0);
      chk("rst_imm", instr_imm, 0);
      chk("rst_instr_pc", instr_pc, 0);
      reset = 1'b0;
      tick();
      chk("idle_to_opcode_valid", instr_valid, 0);
      chk("idle_to_opcode_read", mem_read, 1);
      tick();
      chk("first_valid", instr_valid, 1);
      chk("first_opcode", instr_opcode, 8'h20);
      chk("first_instr_pc", instr_pc, 16'h0000);
      chk("first_pc", pc, 16'h0001);

      // table of single instructions, zero wait states
      for (int v = 0; v < 7; v++) begin
         for (int b = 0; b < 4; b++) mem[16'(vt[v].addr + 16'(b))] = vt[v].bytes[8*b +: 8];
         instr_ready = 1'b0; pc_load = 1'b1; pc_load_value = vt[v].addr;
         tick();
         pc_load = 1'b0;
         run_to_valid(cyc);
         chk($sformatf("v%0d_cycles", v), cyc, vt[v].cyc);
         chk($sformatf("v%0d_opcode", v), instr_opcode, vt[v].op);
         chk($sformatf("v%0d_opext", v), instr_opext, vt[v].ext);
         chk($sformatf("v%0d_has_opext", v), instr_has_opext, vt[v].has);
         chk($sformatf("v%0d_imm", v), instr_imm, vt[v].imm);
         chk($sformatf("v%0d_imm_bytes", v), instr_imm_bytes, vt[v].nb);
         chk($sformatf("v%0d_instr_pc", v), instr_pc, vt[v].addr);
         chk($sformatf("v%0d_pc", v), pc, vt[v].npc);
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
         chk($sformatf("v%0d_valid_drop", v), instr_valid, 0);
      end

      // extension byte with three wait states
      mem[16'h1000] = 8'hCE; mem[16'h1001] = 8'h44; mem[16'h1002] = 8'h34; mem[16'h1003] = 8'h12;
      rs = 7'b1000111;
      xa = '{16'h1000, 16'h1001, 16'h1001, 16'h1001, 16'h1001, 16'h1002, 16'h1003};
      pc_load = 1'b1; pc_load_value = 16'h1000;
      tick();
      pc_load = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rs[i];
         #1;
         chk($sformatf("ws_addr%0d", i), mem_addr, exp_addr(xa[i]));
         chk($sformatf("ws_read%0d", i), mem_read, 1);
         if (i == 0) chk("ws_dec_opcode", dec_opcode, 8'hCE);
         tick();
         chk($sformatf("ws_valid%0d", i), instr_valid, (i == 6) ? 1 : 0);
      end
      mem_ready = 1'b1;
      chk("ws_imm", instr_imm, 16'h1234);
      chk("ws_opext", instr_opext, 8'h44);
      chk("ws_has_opext", instr_has_opext, 1);

      // execute stage stalls five cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold%0d_valid", i), instr_valid, 1);
         chk($sformatf("hold%0d_read", i), mem_read, 0);
         chk($sformatf("hold%0d_pc", i), pc, 16'h1004);
         chk($sformatf("hold%0d_imm", i), instr_imm, 16'h1234);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("hold_release_valid", instr_valid, 0);
      chk("hold_release_read", mem_read, 1);
      chk("hold_release_addr", mem_addr, exp_addr(16'h1004));

      // redirect during the second immediate byte
      mem[16'h2000] = 8'h30; mem[16'h2001] = 8'h11; mem[16'h2002] = 8'h22; mem[16'h8123] = 8'h20;
      pc_load = 1'b1; pc_load_value = 16'h2000;
      tick();
      pc_load = 1'b0;
      tick();
      chk("rd_valid_a", instr_valid, 0);
      tick();
      chk("rd_valid_b", instr_valid, 0);
      chk("rd_pc_before", pc, 16'h2002);
      pc_load = 1'b1; pc_load_value = 16'h8123;
      tick();
      pc_load = 1'b0;
      chk("rd_valid_c", instr_valid, 0);
      chk("rd_pc", pc, 16'h8123);
      chk("rd_addr", mem_addr, exp_addr(16'h8123));
      tick();
      chk("rd_new_valid", instr_valid, 1);
      chk("rd_new_opcode", instr_opcode, 8'h20);
      chk("rd_new_instr_pc", instr_pc, 16'h8123);
      chk("rd_new_imm", instr_imm, 16'h0000);

      // two-byte fetch straddling 0x7FFF -> 0x8000
      mem[16'h7FFF] = 8'h10; mem[16'h8000] = 8'h66;
      pc_load = 1'b1; pc_load_value = 16'h7FFF;
      tick();
      pc_load = 1'b0;
      chk("bank_addr0", mem_addr, exp_addr(16'h7FFF));
      tick();
      chk("bank_addr1", mem_addr, exp_addr(16'h8000));
      tick();
      chk("bank_valid", instr_valid, 1);
      chk("bank_imm", instr_imm, 16'h0066);
      chk("bank_pc", pc, 16'h8001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
